// File: rtl/fetch_stage.sv
// Purpose: IF stage and IF/ID pipeline register of a 5-stage MIPS pipeline.
//   Owns the PC and selects the next PC from PCSrcID and the ID-stage targets.
//   Holds, bubbles or advances IF/ID under the hazard unit's stall/flush.
//   Latches external interrupts and injects a vectored trap when it is safe,
//   handing the interrupted PC to ID.
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   stall, flush       hazard-unit controls (stall has priority over flush)
//   PCSrcID            0 seq, 1 branch, 2 jump, 3 jr, 4 illop, 5-7 seq
//   BranchTargetID, JumpTargetID, JRTargetID   redirect targets from ID
//   interrupt          level-sensitive external interrupt request
//   ImemAddr/ImemData  instruction memory address (= PCIF) and combinational data
//   PCIF               current fetch PC
//   InstID, PCplus4ID, ValidID, IrqTakenID, EPCID   IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
  parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  PCSrcID,
  input  logic [31:0] BranchTargetID,
  input  logic [31:0] JumpTargetID,
  input  logic [31:0] JRTargetID,
  input  logic        interrupt,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] PCIF,
  output logic [31:0] InstID,
  output logic [31:0] PCplus4ID,
  output logic        ValidID,
  output logic        IrqTakenID,
  output logic [31:0] EPCID
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;
  logic            r_irq_taken;
  logic [XLEN-1:0] r_epc;
  logic            r_irq_pending;

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_redirect;
  logic            w_irq_latch;
  logic            w_take;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_pc4_nxt;
  logic            w_valid_nxt;
  logic            w_irq_taken_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic            w_irq_pending_nxt;

  // Sequential PC: 31-bit wrap, kernel bit preserved.
  assign w_seq = {r_pc[XLEN-1], (XLEN-1)'(r_pc[XLEN-2:0] + (XLEN-1)'(4))};

  // Kernel mode masks both latching and taking of interrupts.
  assign w_irq_latch = interrupt & ~r_pc[XLEN-1];
  assign w_take      = r_irq_pending & ~r_pc[XLEN-1] & (PCSrcID == 3'd0);

  // Redirect target for a flush; unused encodings fall back to sequential.
  always_comb begin
    w_redirect = w_seq;
    case (PCSrcID)
      3'd1:    w_redirect = BranchTargetID;
      3'd2:    w_redirect = JumpTargetID;
      3'd3:    w_redirect = JRTargetID;
      3'd4:    w_redirect = ILLOP_VECTOR;
      default: w_redirect = w_seq;
    endcase
  end

  // Next-state selection in priority order: stall, flush, irq take, advance.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_inst_nxt        = r_inst;
    w_pc4_nxt         = r_pc4;
    w_valid_nxt       = r_valid;
    w_irq_taken_nxt   = r_irq_taken;
    w_epc_nxt         = r_epc;
    w_irq_pending_nxt = r_irq_pending | w_irq_latch;
    if (stall) begin
      // hold everything except interrupt latching
    end else if (flush) begin
      w_pc_nxt        = w_redirect;
      w_inst_nxt      = '0;
      w_pc4_nxt       = '0;
      w_valid_nxt     = 1'b0;
      w_irq_taken_nxt = 1'b0;
    end else if (w_take) begin
      // Fetched word is dropped; it is re-fetched from EPC after eret.
      w_pc_nxt          = IRQ_VECTOR;
      w_inst_nxt        = '0;
      w_pc4_nxt         = '0;
      w_valid_nxt       = 1'b0;
      w_irq_taken_nxt   = 1'b1;
      w_epc_nxt         = r_pc;
      w_irq_pending_nxt = 1'b0;
    end else begin
      w_pc_nxt        = w_seq;
      w_inst_nxt      = ImemData;
      w_pc4_nxt       = w_seq;
      w_valid_nxt     = 1'b1;
      w_irq_taken_nxt = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_VECTOR;
      r_inst        <= '0;
      r_pc4         <= '0;
      r_valid       <= 1'b0;
      r_irq_taken   <= 1'b0;
      r_epc         <= '0;
      r_irq_pending <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_inst        <= w_inst_nxt;
      r_pc4         <= w_pc4_nxt;
      r_valid       <= w_valid_nxt;
      r_irq_taken   <= w_irq_taken_nxt;
      r_epc         <= w_epc_nxt;
      r_irq_pending <= w_irq_pending_nxt;
    end
  end

  assign ImemAddr   = r_pc;
  assign PCIF       = r_pc;
  assign InstID     = r_inst;
  assign PCplus4ID  = r_pc4;
  assign ValidID    = r_valid;
  assign IrqTakenID = r_irq_taken;
  assign EPCID      = r_epc;

endmodule
